// File: rtl/regfile_wb_pkg.sv
// Shared constants and request type for the register-file writeback arbiter.
// Build option: WB_STARVE_GUARD_EN enables the port-1 starvation guard.
package regfile_wb_pkg;

  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;

  localparam int WB_PORT_PIPE = 0;
  localparam int WB_PORT_LONG = 1;

  typedef struct packed {
    logic                     valid;
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req;

endpackage

// File: rtl/regfile_wb_arbiter_starve_counter.sv
// Counts consecutive blocked cycles of the long-latency port and raises a
// registered boost once the wait reaches MAX_WAIT. Used under WB_STARVE_GUARD_EN.
module wb_starve_counter #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic wb1_valid,
  input  logic wb1_ready,
  output logic boost
);

  localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  logic [CW-1:0] wait_cnt;
  logic          blocked;
  logic          xfer;

  assign blocked = wb1_valid && !wb1_ready;
  assign xfer    = wb1_valid && wb1_ready;

  // Boost rises on the edge where the count reaches its limit, so it is
  // visible in the very next cycle and drops once port 1 gets through.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      boost    <= 1'b0;
    end else if (!wb1_valid || xfer) begin
      wait_cnt <= '0;
      boost    <= 1'b0;
    end else if (blocked) begin
      if (wait_cnt != CNT_MAX) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (wait_cnt == CNT_LAST) begin
        boost <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source write-port arbiter feeding the register file with registered outputs.
// Build option: WB_STARVE_GUARD_EN adds the starvation counter and boost.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH    = WB_DATA_WIDTH,
  parameter int MAX_WAIT      = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb0_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb0_addr,
  input  logic [DATA_WIDTH-1:0]    wb0_data,
  output logic                     wb0_ready,
  input  logic                     wb1_valid,
  input  logic [ADDRESS_WIDTH-1:0] wb1_addr,
  input  logic [DATA_WIDTH-1:0]    wb1_data,
  output logic                     wb1_ready,
  output logic                     rf_we,
  output logic [ADDRESS_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     boost
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("regfile_wb_arbiter: MAX_WAIT must be in 1..255");
  end

  logic [1:0]               ready_vec;
  logic                     xfer0;
  logic                     xfer1;
  logic [ADDRESS_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0]    win_data;

`ifdef WB_STARVE_GUARD_EN
  wb_starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk       (clk),
    .reset     (reset),
    .wb1_valid (wb1_valid),
    .wb1_ready (wb1_ready),
    .boost     (boost)
  );
`else
  assign boost = 1'b0;
`endif

  // Grants depend only on valids and the registered boost, never on ready.
  always_comb begin
    ready_vec = 2'b00;
    if (reset) begin
      if (boost) begin
        ready_vec[WB_PORT_LONG] = wb1_valid;
      end else begin
        ready_vec[WB_PORT_PIPE] = wb0_valid;
        ready_vec[WB_PORT_LONG] = wb1_valid && !wb0_valid;
      end
    end
  end

  assign wb0_ready = ready_vec[WB_PORT_PIPE];
  assign wb1_ready = ready_vec[WB_PORT_LONG];
  assign xfer0     = wb0_valid && wb0_ready;
  assign xfer1     = wb1_valid && wb1_ready;

  always_comb begin
    win_addr = wb1_addr;
    win_data = wb1_data;
    if (xfer0) begin
      win_addr = wb0_addr;
      win_data = wb0_data;
    end
  end

  // Writes to r0 are accepted but never reach the register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (xfer0 || xfer1) begin
        rf_we    <= (win_addr != '0);
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter; starvation expectations
// follow whether WB_STARVE_GUARD_EN is defined.
module tb_regfile_wb_arbiter;

`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb0_valid, wb1_valid;
  logic [4:0]  wb0_addr, wb1_addr;
  logic [31:0] wb0_data, wb1_data;
  logic        wb0_ready, wb1_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        boost;

  int nAsserts = 0;
  int nFails   = 0;

  regfile_wb_arbiter #(
    .ADDRESS_WIDTH (5),
    .DATA_WIDTH    (32),
    .MAX_WAIT      (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wb0_valid (wb0_valid),
    .wb0_addr  (wb0_addr),
    .wb0_data  (wb0_data),
    .wb0_ready (wb0_ready),
    .wb1_valid (wb1_valid),
    .wb1_addr  (wb1_addr),
    .wb1_data  (wb1_data),
    .wb1_ready (wb1_ready),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .boost     (boost)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
    wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit w1Pending;
    bit expW1;

    // Reset with a request present
    reset = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd6, 32'h5A5A5A5A);
    #1;
    checkOutput("rst_wb0_ready", 32'(wb0_ready), 32'd0);
    checkOutput("rst_wb1_ready", 32'(wb1_ready), 32'd0);
    checkOutput("rst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    checkOutput("rst_rf_wdata", rf_wdata, 32'd0);
    checkOutput("rst_boost", 32'(boost), 32'd0);
    tick();
    checkOutput("rst_hold_rf_we", 32'(rf_we), 32'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("rst_release_rf_we", 32'(rf_we), 32'd0);

    // Single port write
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    #1;
    checkOutput("single_wb0_ready", 32'(wb0_ready), 32'd1);
    checkOutput("single_wb1_ready", 32'(wb1_ready), 32'd0);
    tick();
    checkOutput("single_rf_we", 32'(rf_we), 32'd1);
    checkOutput("single_rf_waddr", 32'(rf_waddr), 32'd5);
    checkOutput("single_rf_wdata", rf_wdata, 32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("single_after_we", 32'(rf_we), 32'd0);
    checkOutput("single_hold_waddr", 32'(rf_waddr), 32'd5);
    checkOutput("single_hold_wdata", rf_wdata, 32'hDEADBEEF);

    // Collision: port 0 first, then port 1
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
    #1;
    checkOutput("coll_wb0_ready", 32'(wb0_ready), 32'd1);
    checkOutput("coll_wb1_ready", 32'(wb1_ready), 32'd0);
    tick();
    checkOutput("coll_first_we", 32'(rf_we), 32'd1);
    checkOutput("coll_first_addr", 32'(rf_waddr), 32'd3);
    checkOutput("coll_first_data", rf_wdata, 32'h11);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22);
    #1;
    checkOutput("coll_wb1_granted", 32'(wb1_ready), 32'd1);
    tick();
    checkOutput("coll_second_we", 32'(rf_we), 32'd1);
    checkOutput("coll_second_addr", 32'(rf_waddr), 32'd4);
    checkOutput("coll_second_data", rf_wdata, 32'h22);

    // Write to r0 is accepted but dropped
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    checkOutput("r0_wb1_ready", 32'(wb1_ready), 32'd1);
    tick();
    checkOutput("r0_rf_we", 32'(rf_we), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("r0_idle_we", 32'(rf_we), 32'd0);

    // Starvation: port 0 valid for 10 cycles, port 1 waiting from cycle 1
    w1Pending = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      applyStimulus(1'b1, 5'(i + 8), 32'h1000 + 32'(i), w1Pending, 5'd9, 32'h99);
      #1;
      expW1 = w1Pending && GUARD && (i == 5);
      checkOutput($sformatf("starve_boost_c%0d", i), 32'(boost), 32'(expW1));
      checkOutput($sformatf("starve_wb0_ready_c%0d", i), 32'(wb0_ready), 32'(!expW1));
      checkOutput($sformatf("starve_wb1_ready_c%0d", i), 32'(wb1_ready), 32'(expW1));
      tick();
      checkOutput($sformatf("starve_rf_we_c%0d", i), 32'(rf_we), 32'd1);
      checkOutput($sformatf("starve_rf_waddr_c%0d", i), 32'(rf_waddr), expW1 ? 32'd9 : 32'(i + 8));
      checkOutput($sformatf("starve_rf_wdata_c%0d", i), rf_wdata, expW1 ? 32'h99 : 32'h1000 + 32'(i));
      if (expW1) w1Pending = 1'b0;
    end
    checkOutput("starve_w1_served_by_guard", 32'(w1Pending), 32'(!GUARD));
    if (w1Pending) begin
      applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
      #1;
      checkOutput("strict_wb1_ready", 32'(wb1_ready), 32'd1);
      tick();
      checkOutput("strict_rf_waddr", 32'(rf_waddr), 32'd9);
      checkOutput("strict_rf_wdata", rf_wdata, 32'h99);
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("starve_end_boost", 32'(boost), 32'd0);

    // Throughput: 8 back-to-back writes to r1..r8
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 5'(i), 32'hC0DE0000 + 32'(i), 1'b0, 5'd0, 32'd0);
      #1;
      checkOutput($sformatf("tput_wb0_ready_%0d", i), 32'(wb0_ready), 32'd1);
      tick();
      checkOutput($sformatf("tput_rf_we_%0d", i), 32'(rf_we), 32'd1);
      checkOutput($sformatf("tput_rf_waddr_%0d", i), 32'(rf_waddr), 32'(i));
      checkOutput($sformatf("tput_rf_wdata_%0d", i), rf_wdata, 32'hC0DE0000 + 32'(i));
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("tput_end_we", 32'(rf_we), 32'd0);

    // Reset mid-transfer discards the registered write
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("midrst_pre_we", 32'(rf_we), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_rf_we", 32'(rf_we), 32'd0);
    checkOutput("midrst_rf_waddr", 32'(rf_waddr), 32'd0);
    checkOutput("midrst_boost", 32'(boost), 32'd0);
    checkOutput("midrst_wb0_ready", 32'(wb0_ready), 32'd0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    tick();
    checkOutput("midrst_release_we", 32'(rf_we), 32'd0);
    checkOutput("midrst_release_wdata", rf_wdata, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter for the 32x32 register file.

- Shares the single register-file write port (regwrite_en / write_addr / write_data) between two writeback sources:
  - port 0: the main pipeline writeback stage.
  - port 1: the long-latency unit (load/mul/div return path).
- Port 0 has fixed priority.
- A starvation guard forces a port-1 grant after a bounded wait.
- Outputs are registered and connect directly to the register file's write inputs.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register address width
- DATA_WIDTH, 32, register data width
- MAX_WAIT, 4, consecutive blocked cycles of port 1 before it is boosted (legal range 1..255)

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-low reset
- wb0_valid  input  1  port 0 write request
- wb0_addr  input  ADDRESS_WIDTH  port 0 destination register
- wb0_data  input  DATA_WIDTH  port 0 write data
- wb0_ready  output  1  port 0 accepted this cycle
- wb1_valid  input  1  port 1 write request
- wb1_addr  input  ADDRESS_WIDTH  port 1 destination register
- wb1_data  input  DATA_WIDTH  port 1 write data
- wb1_ready  output  1  port 1 accepted this cycle
- rf_we  output  1  to register file regwrite_en
- rf_waddr  output  ADDRESS_WIDTH  to register file write_addr
- rf_wdata  output  DATA_WIDTH  to register file write_data
- boost  output  1  starvation boost active (status)

## Operation
Handshake:
- valid/ready. A transfer occurs at a rising edge when valid && ready.
- A requester holds valid, addr and data stable until ready.
- ready is combinational from valid and the internal state.
- ready never depends on itself.

Grant rules:
- boost=0: wb0_ready = wb0_valid; wb1_ready = wb1_valid && !wb0_valid.
- boost=1: wb0_ready = 0; wb1_ready = wb1_valid.
- At most one ready is high in any cycle.

Output register:
- On a transfer, rf_waddr/rf_wdata load the winner's addr/data.
- rf_we loads 1, except when the winner's addr == 0: the transfer is still accepted but rf_we loads 0 (writes to r0 are dropped).
- With no transfer, rf_we loads 0 and rf_waddr/rf_wdata hold their values.

Starvation counter (wait_cnt, width $clog2(MAX_WAIT+1)):
- Increments (saturating at MAX_WAIT) each cycle wb1_valid && !wb1_ready.
- Clears on a port-1 transfer.
- Clears when wb1_valid=0.
- boost is registered: boost loads 1 at the edge where wait_cnt would reach MAX_WAIT.
- boost loads 0 at the port-1 transfer edge, or when wb1_valid drops.

Reset (reset=0):
- rf_we=0, rf_waddr=0, rf_wdata=0, wait_cnt=0, boost=0 immediately.
- wb0_ready/wb1_ready are forced 0 while reset is low.
- Reset mid-operation discards any registered, not-yet-written transfer.

## Timing
- Latency: transfer at edge N puts rf_we=1 in cycle N..N+1; the register file commits at edge N+1.
- Back-to-back transfers sustain one write per cycle.
- Simultaneous valid with boost=0: port 0 wins; port 1 waits.
- With MAX_WAIT=M and port 0 continuously valid:
  - port 1 blocks for M cycles;
  - boost is high in cycle M+1;
  - port 1 transfers in that cycle;
  - port 0 is stalled that one cycle.
- Same-address writes from both ports: they are serialized in grant order, so the last granted value persists.
- Read-after-write forwarding is not provided; the pipeline handles it.

## Configuration
- Macro WB_STARVE_GUARD_EN:
  - Defined: starvation counter and boost logic as above.
  - Undefined: strict fixed priority. boost is tied 0, wait_cnt is absent, and port 1 is granted only when wb0_valid=0. MAX_WAIT is ignored.

## Structure
- Package regfile_wb_pkg holds:
  - default ADDRESS_WIDTH/DATA_WIDTH constants;
  - port index constants WB_PORT_PIPE=0 and WB_PORT_LONG=1;
  - a wb_req typedef (valid, addr, data).
- One sub-module, wb_starve_counter, contains wait_cnt and boost. It is instantiated only under WB_STARVE_GUARD_EN.

## Test plan
- Reset: assert reset=0 mid-transfer with wb0_valid=1 → rf_we=0, boost=0 immediately. No write occurs at the next edge after release unless re-requested.
- Single port: wb0 writes addr 5 data 0xDEADBEEF → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF one cycle later; rf_we=0 the cycle after.
- Collision: both valid, wb0 addr 3 data 0x11, wb1 addr 4 data 0x22 →
  - cycle 1: wb0_ready=1, wb1_ready=0;
  - next cycle port 1 is granted (wb0_valid dropped);
  - writes appear in order r3 then r4.
- r0 drop: wb1 writes addr 0 data 0xFFFFFFFF → wb1_ready=1, rf_we stays 0.
- Starvation: MAX_WAIT=4, wb0_valid held 1 for 10 cycles, wb1_valid=1 →
  - boost high in cycle 5;
  - wb1 transfers in cycle 5 and wb0_ready=0 that cycle;
  - boost=0 in cycle 6.
  - Without WB_STARVE_GUARD_EN, wb1 waits all 10 cycles.
- Throughput: wb0 streams 8 consecutive writes to r1..r8 → 8 consecutive rf_we=1 cycles with matching addr/data.
